// File: rtl/unidade_de_pilha_pkg.sv
// Shared constants for the stack unit and the control unit that drives it:
// default sizes, pilha field encodings and the decoded operation type.
package unidade_de_pilha_pkg;

  // Default word width and stack depth.
  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 16;

  // Encodings of the pilha field coming from the control unit.
  localparam logic [1:0] PILHA_NENHUMA = 2'b00;
  localparam logic [1:0] PILHA_RET     = 2'b01;
  localparam logic [1:0] PILHA_DADO    = 2'b10;

  // Operation decoded from habilita / pilha / emp_desemp.
  typedef enum logic [1:0] {
    OP_NADA       = 2'b00,
    OP_EMPILHA    = 2'b01,
    OP_DESEMPILHA = 2'b10
  } operacao_t;

  // The data stack selection (bit1) wins over the return-address selection.
  function automatic logic usa_dado(input logic [1:0] campo_pilha);
    return campo_pilha[1];
  endfunction

endpackage

// File: rtl/unidade_de_pilha_memoria_pilha.sv
// Stack storage: PROFUNDIDADE x LARGURA register array with a synchronous
// write port and an asynchronous read port. Contents are not reset; only
// the stack pointer in the parent decides which entries are meaningful.
module memoria_pilha
  import unidade_de_pilha_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  localparam int AW          = $clog2(PROFUNDIDADE)
) (
  input  logic               clock,
  input  logic               escreve,
  input  logic [AW-1:0]      endereco_escrita,
  input  logic [LARGURA-1:0] dado_escrita,
  input  logic [AW-1:0]      endereco_leitura,
  output logic [LARGURA-1:0] dado_leitura
);

  logic [LARGURA-1:0] mem_r [PROFUNDIDADE];

  // Write one entry on the rising edge when the parent requests it.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem_r[endereco_escrita] <= dado_escrita;
    end
  end

  assign dado_leitura = mem_r[endereco_leitura];

endmodule

// File: rtl/unidade_de_pilha.sv
// Hardware stack shared by return addresses and register data.
// Holds the entry counter, sticky overflow/underflow flags and the
// registered pop output; storage lives in memoria_pilha.
module unidade_de_pilha
  import unidade_de_pilha_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          habilita,
  input  logic [1:0]                    pilha,
  input  logic                          emp_desemp,
  input  logic [LARGURA-1:0]            pc_ret,
  input  logic [LARGURA-1:0]            dado_in,
  output logic [LARGURA-1:0]            dado_out,
  output logic                          valido,
  output logic                          cheia,
  output logic                          vazia,
  output logic [1:0]                    erro,
  output logic [$clog2(PROFUNDIDADE):0] sp
);

  localparam int AW  = $clog2(PROFUNDIDADE);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_MAX  = SPW'(PROFUNDIDADE);
  localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
  localparam logic [SPW-1:0] SP_UM   = {{AW{1'b0}}, 1'b1};

  logic [SPW-1:0]     sp_r;
  logic [LARGURA-1:0] dado_out_r;
  logic               valido_r;
  logic [1:0]         erro_r;

  operacao_t          operacao_s;
  logic [LARGURA-1:0] fonte_s;
  logic               cheia_s;
  logic               vazia_s;
  logic               escreve_s;
  logic [AW-1:0]      endereco_escrita_s;
  logic [AW-1:0]      endereco_leitura_s;
  logic [LARGURA-1:0] dado_leitura_s;

  // Full/empty come straight from the registered counter.
  assign cheia_s = (sp_r == SP_MAX);
  assign vazia_s = (sp_r == SP_ZERO);

  // Decode the instruction strobe into a single operation.
  always_comb begin
    operacao_s = OP_NADA;
    if (habilita && (pilha != PILHA_NENHUMA)) begin
      if (emp_desemp) begin
        operacao_s = OP_EMPILHA;
      end else begin
        operacao_s = OP_DESEMPILHA;
      end
    end else begin
      operacao_s = OP_NADA;
    end
  end

  // Select the word to push; data stack selection has priority.
  always_comb begin
    fonte_s = {LARGURA{1'b0}};
    if (usa_dado(pilha)) begin
      fonte_s = dado_in;
    end else begin
      fonte_s = pc_ret;
    end
  end

  // A push writes the slot at sp; a pop reads the slot just below it.
  // Reset suppresses the write so it fully overrides a concurrent push.
  assign escreve_s          = (operacao_s == OP_EMPILHA) && !cheia_s && !reset;
  assign endereco_escrita_s = sp_r[AW-1:0];
  assign endereco_leitura_s = sp_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

  memoria_pilha #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_memoria_pilha (
    .clock            (clock),
    .escreve          (escreve_s),
    .endereco_escrita (endereco_escrita_s),
    .dado_escrita     (fonte_s),
    .endereco_leitura (endereco_leitura_s),
    .dado_leitura     (dado_leitura_s)
  );

  // Counter, sticky error flags and registered pop output.
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_r       <= SP_ZERO;
      dado_out_r <= {LARGURA{1'b0}};
      valido_r   <= 1'b0;
      erro_r     <= 2'b00;
    end else begin
      case (operacao_s)
        OP_EMPILHA: begin
          valido_r <= 1'b0;
          if (cheia_s) begin
            erro_r[1] <= 1'b1;
          end else begin
            sp_r <= sp_r + SP_UM;
          end
        end
        OP_DESEMPILHA: begin
          valido_r <= 1'b1;
          if (vazia_s) begin
            dado_out_r <= {LARGURA{1'b0}};
            erro_r[0]  <= 1'b1;
          end else begin
            dado_out_r <= dado_leitura_s;
            sp_r       <= sp_r - SP_UM;
          end
        end
        default: begin
          valido_r <= 1'b0;
        end
      endcase
    end
  end

  assign dado_out = dado_out_r;
  assign valido   = valido_r;
  assign erro     = erro_r;
  assign sp       = sp_r;
  assign cheia    = cheia_s;
  assign vazia    = vazia_s;

endmodule
